// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/debug memory arbiter: state encoding,
// owner ids and the round-robin picker.
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

    // On a tie the requester that was not granted last wins.
    function automatic logic pick_owner(input logic cpu_elig,
                                        input logic dbg_elig,
                                        input logic last_owner);
        if (cpu_elig && dbg_elig)
            return ~last_owner;
        else if (cpu_elig)
            return OWNER_CPU;
        else
            return OWNER_DBG;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one SPI memory controller bus between the CPU and the debug/loader
// port; the grant is held for a whole transaction, followed by a release cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data_tx,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [7:0]  cpu_data_rx,
    output logic        cpu_wait,

    input  logic [15:0] dbg_address,
    input  logic [7:0]  dbg_data_tx,
    input  logic        dbg_read,
    input  logic        dbg_write,
    output logic [7:0]  dbg_data_rx,
    output logic        dbg_wait,

    input  logic        dbg_hold,
    output logic        cpu_stalled,

    output logic [15:0] mem_address,
    output logic [7:0]  mem_data_tx,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [7:0]  mem_data_rx,
    input  logic        mem_wait
);

    logic [1:0] state;
    logic       owner;
    logic       last_owner;

    logic cpu_req;
    logic dbg_req;
    logic cpu_elig;
    logic grant_owner;
    logic busy;
    logic done;

    assign cpu_req     = cpu_read | cpu_write;
    assign dbg_req     = dbg_read | dbg_write;
    assign cpu_elig    = cpu_req & ~dbg_hold;
    assign grant_owner = pick_owner(cpu_elig, dbg_req, last_owner);
    assign busy        = (state == ST_BUSY);
    assign done        = busy & ~mem_wait;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= OWNER_CPU;
            last_owner <= OWNER_DBG;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_elig || dbg_req) begin
                        state      <= ST_BUSY;
                        owner      <= grant_owner;
                        last_owner <= grant_owner;
                    end
                end
                ST_BUSY: begin
                    if (!mem_wait)
                        state <= ST_RELEASE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        mem_address = 16'h0000;
        mem_data_tx = 8'h00;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        if (busy) begin
            if (owner == OWNER_CPU) begin
                mem_address = cpu_address;
                mem_data_tx = cpu_data_tx;
                mem_read    = cpu_read;
                mem_write   = cpu_write;
            end else begin
                mem_address = dbg_address;
                mem_data_tx = dbg_data_tx;
                mem_read    = dbg_read;
                mem_write   = dbg_write;
            end
        end
    end

    assign cpu_wait    = ~(done && owner == OWNER_CPU);
    assign dbg_wait    = ~(done && owner == OWNER_DBG);
    assign cpu_data_rx = mem_data_rx;
    assign dbg_data_rx = mem_data_rx;

    // A CPU that already owns the bus is not blocked by a late dbg_hold.
    assign cpu_stalled = cpu_req & dbg_hold & ~(busy && owner == OWNER_CPU);

endmodule
